conway_sequencer: RTL and testbench



---
 rtl/conway_pkg.sv | 25 ++
 rtl/conway_period_timer.sv | 28 ++
 rtl/conway_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_conway_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared types and defaults for the Game-of-Life sequencer slice.
package conway_pkg;

   localparam int OP_W     = 2;
   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;

   typedef enum logic [OP_W-1:0] {
      CMD_LOAD = 2'd0,
      CMD_STEP = 2'd1,
      CMD_RUN  = 2'd2,
      CMD_HALT = 2'd3
   } cmd_op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STEP_ENA,
      S_CHECK,
      S_RUN_WAIT,
      S_RUN_ENA,
      S_RUN_CHECK
   } seq_state_t;

endpackage

// File: rtl/conway_period_timer.sv
// Loadable down-counter pacing free-run generations; holds at zero.
module conway_period_timer
   import conway_pkg::*;
#(
   parameter int PER_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PER_W-1:0] value,
   output logic             zero
);

   logic [PER_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/conway_sequencer.sv
// Command sequencer for a Game-of-Life cell array: load, step, free-run, halt,
// with generation counting and still-life / extinction detection.
module conway_sequencer
   import conway_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS,
   parameter int GEN_W = 16,
   parameter int PER_W = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [OP_W-1:0]      cmd_op,
   input  logic [PER_W-1:0]     cmd_period,
   input  logic [ROWS*COLS-1:0] seed,
   input  logic [ROWS*COLS-1:0] board_q,
   output logic [ROWS*COLS-1:0] board_seed,
   output logic                 board_load,
   output logic                 board_ena,
   output logic [GEN_W-1:0]     generation,
   output logic                 busy,
   output logic                 done,
   output logic                 stable,
   output logic                 extinct,
   output logic                 cmd_err
);

   localparam int N = ROWS * COLS;

   seq_state_t     state;
   cmd_op_t        op;
   logic [N-1:0]   snapshot;
   logic [PER_W-1:0] per_m1;
   logic [PER_W-1:0] per_in_m1;
   logic           accept;
   logic           gen_max;
   logic           nxt_stable;
   logic           nxt_extinct;
   logic           run_stop;
   logic           tmr_load;
   logic [PER_W-1:0] tmr_value;
   logic           tmr_zero;

   assign op          = cmd_op_t'(cmd_op);
   assign cmd_ready   = (state == S_IDLE) || (state == S_RUN_WAIT);
   assign busy        = (state != S_IDLE);
   assign accept      = cmd_valid && cmd_ready;
   assign gen_max     = (generation == '1);
   assign per_in_m1   = (cmd_period == '0) ? '0 : cmd_period - 1'b1;
   assign nxt_stable  = (board_q == snapshot);
   assign nxt_extinct = (board_q == '0);
   assign run_stop    = nxt_stable || nxt_extinct || gen_max;

   // RUN_WAIT lasts P-1 cycles (the timer is loaded with P-2) so that with the
   // ENA and CHECK cycles the strobes land P+1 apart; P=1 skips RUN_WAIT.
   always_comb begin
      tmr_load  = 1'b0;
      tmr_value = '0;
      if (state == S_IDLE && accept && op == CMD_RUN && !gen_max && per_in_m1 != '0) begin
         tmr_load  = 1'b1;
         tmr_value = per_in_m1 - 1'b1;
      end else if (state == S_RUN_CHECK && !run_stop && per_m1 != '0) begin
         tmr_load  = 1'b1;
         tmr_value = per_m1 - 1'b1;
      end
   end

   conway_period_timer #(.PER_W(PER_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         board_seed <= '0;
         board_load <= 1'b0;
         board_ena  <= 1'b0;
         generation <= '0;
         done       <= 1'b0;
         stable     <= 1'b0;
         extinct    <= 1'b0;
         cmd_err    <= 1'b0;
         snapshot   <= '0;
         per_m1     <= '0;
      end else begin
         board_load <= 1'b0;
         board_ena  <= 1'b0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     CMD_LOAD: begin
                        board_seed <= seed;
                        generation <= '0;
                        stable     <= 1'b0;
                        extinct    <= 1'b0;
                        board_load <= 1'b1;
                        done       <= 1'b1;
                        state      <= S_LOAD;
                     end
                     CMD_STEP: begin
                        if (gen_max) begin
                           cmd_err <= 1'b1;
                        end else begin
                           snapshot   <= board_q;
                           board_ena  <= 1'b1;
                           generation <= generation + 1'b1;
                           state      <= S_STEP_ENA;
                        end
                     end
                     CMD_RUN: begin
                        if (gen_max) begin
                           cmd_err <= 1'b1;
                        end else begin
                           per_m1 <= per_in_m1;
                           if (per_in_m1 == '0) begin
                              snapshot   <= board_q;
                              board_ena  <= 1'b1;
                              generation <= generation + 1'b1;
                              state      <= S_RUN_ENA;
                           end else begin
                              state <= S_RUN_WAIT;
                           end
                        end
                     end
                     default: cmd_err <= 1'b1;
                  endcase
               end
            end
            S_LOAD: state <= S_IDLE;
            S_STEP_ENA: begin
               done  <= 1'b1;
               state <= S_CHECK;
            end
            S_CHECK: begin
               stable  <= nxt_stable;
               extinct <= nxt_extinct;
               state   <= S_IDLE;
            end
            S_RUN_WAIT: begin
               if (accept && op == CMD_HALT) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  cmd_err <= accept;
                  if (tmr_zero) begin
                     snapshot   <= board_q;
                     board_ena  <= 1'b1;
                     generation <= generation + 1'b1;
                     state      <= S_RUN_ENA;
                  end
               end
            end
            S_RUN_ENA: state <= S_RUN_CHECK;
            S_RUN_CHECK: begin
               stable  <= nxt_stable;
               extinct <= nxt_extinct;
               if (run_stop) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else if (per_m1 == '0) begin
                  snapshot   <= board_q;
                  board_ena  <= 1'b1;
                  generation <= generation + 1'b1;
                  state      <= S_RUN_ENA;
               end else begin
                  state <= S_RUN_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conway_sequencer.sv
// Bench for conway_sequencer: a Life array model drives board_q, and a per-cycle
// schedule of expected outputs is planned from each accepted command.
module tb_conway_sequencer;

   localparam int ROWS  = 5;
   localparam int COLS  = 5;
   localparam int N     = ROWS * COLS;
   localparam int GEN_W = 2;
   localparam int PER_W = 8;
   localparam int GMAX  = (1 << GEN_W) - 1;
   localparam int MAXC  = 2048;

   localparam int OP_LOAD = 0;
   localparam int OP_STEP = 1;
   localparam int OP_RUN  = 2;
   localparam int OP_HALT = 3;

   localparam logic [N-1:0] BLINK  = 25'h0003800;
   localparam logic [N-1:0] VBLINK = 25'h0021080;
   localparam logic [N-1:0] BLOCK  = 25'h00018C0;
   localparam logic [N-1:0] SINGLE = 25'h0001000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = '0;
   logic [PER_W-1:0] cmd_period = '0;
   logic [N-1:0]     seed = '0;
   logic [N-1:0]     board_q;
   logic [N-1:0]     board_seed;
   logic             board_load;
   logic             board_ena;
   logic [GEN_W-1:0] generation;
   logic             busy;
   logic             done;
   logic             stable;
   logic             extinct;
   logic             cmd_err;

   conway_sequencer #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .PER_W(PER_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_period (cmd_period),
      .seed       (seed),
      .board_q    (board_q),
      .board_seed (board_seed),
      .board_load (board_load),
      .board_ena  (board_ena),
      .generation (generation),
      .busy       (busy),
      .done       (done),
      .stable     (stable),
      .extinct    (extinct),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ena_cnt = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) ena_cnt <= ena_cnt + (board_ena === 1'b1 ? 1 : 0);

   function automatic logic [N-1:0] life(input logic [N-1:0] b);
      logic [N-1:0] r;
      int n;
      r = '0;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < ROWS &&
                      x + dx >= 0 && x + dx < COLS && b[(y + dy) * COLS + x + dx])
                     n++;
            r[y * COLS + x] = (n == 3) || (n == 2 && b[y * COLS + x]);
         end
      end
      return r;
   endfunction

   // The cell array: reacts to the DUT strobes.
   logic [N-1:0] cells = '0;
   always @(posedge clk) begin
      if (board_load) cells <= board_seed;
      else if (board_ena) cells <= life(cells);
   end
   assign board_q = cells;

   // Expected value per cycle index (interval following posedge number k).
   bit           e_load[MAXC], e_ena[MAXC], e_done[MAXC], e_err[MAXC];
   bit           e_busy[MAXC], e_ready[MAXC], e_stable[MAXC], e_ext[MAXC];
   int           e_gen[MAXC];
   logic [N-1:0] e_seed[MAXC];

   int           m_gen, m_idle_at, run_a;
   bit           m_run;
   logic [N-1:0] m_board, run_b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic fill_gen(input int k, input int v);
      for (int i = k; i < MAXC; i++) e_gen[i] = v;
   endtask

   task automatic fill_st(input int k, input bit s, input bit x);
      for (int i = k; i < MAXC; i++) begin
         e_stable[i] = s;
         e_ext[i]    = x;
      end
   endtask

   task automatic m_reset(input int k);
      for (int i = k; i < MAXC; i++) begin
         e_load[i] = 0; e_ena[i] = 0; e_done[i] = 0; e_err[i] = 0;
         e_busy[i] = 0; e_ready[i] = 1; e_stable[i] = 0; e_ext[i] = 0;
         e_gen[i] = 0; e_seed[i] = '0;
      end
      m_gen = 0; m_idle_at = k; m_run = 0;
   endtask

   task automatic m_accept(input int op, input int per, input logic [N-1:0] sd, input int a);
      int ng, t, e, g, p;
      bit s, x, stop;
      logic [N-1:0] b, nb;
      if (m_run && a < m_idle_at) begin
         if (op == OP_HALT) begin
            ng = 0;
            for (int i = run_a; i < a; i++) if (e_ena[i]) ng++;
            for (int i = a; i < MAXC; i++) begin
               e_ena[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_ready[i] = 1;
            end
            e_done[a] = 1;
            fill_gen(a, e_gen[a-1]);
            fill_st(a, e_stable[a-1], e_ext[a-1]);
            b = run_b0;
            repeat (ng) b = life(b);
            m_board = b; m_gen = e_gen[a-1]; m_idle_at = a; m_run = 0;
         end else begin
            e_err[a] = 1;
         end
      end else begin
         case (op)
            OP_LOAD: begin
               e_load[a] = 1; e_done[a] = 1; e_busy[a] = 1; e_ready[a] = 0;
               for (int i = a; i < MAXC; i++) e_seed[i] = sd;
               fill_gen(a, 0); fill_st(a, 0, 0);
               m_board = sd; m_gen = 0; m_idle_at = a + 1; m_run = 0;
            end
            OP_STEP: begin
               if (m_gen == GMAX) e_err[a] = 1;
               else begin
                  e_ena[a] = 1;
                  e_busy[a] = 1; e_ready[a] = 0; e_busy[a+1] = 1; e_ready[a+1] = 0;
                  e_done[a+1] = 1;
                  m_gen++; fill_gen(a, m_gen);
                  nb = life(m_board);
                  fill_st(a + 2, nb == m_board, nb == '0);
                  m_board = nb; m_idle_at = a + 2; m_run = 0;
               end
            end
            OP_RUN: begin
               if (m_gen == GMAX) e_err[a] = 1;
               else begin
                  p = (per == 0) ? 1 : per;
                  t = a; g = m_gen; b = m_board; stop = 0;
                  run_a = a; run_b0 = m_board;
                  while (!stop) begin
                     for (int i = t; i < t + p - 1; i++) e_busy[i] = 1;
                     e = t + p - 1;
                     e_ena[e] = 1;
                     e_busy[e] = 1; e_ready[e] = 0; e_busy[e+1] = 1; e_ready[e+1] = 0;
                     g++; fill_gen(e, g);
                     nb = life(b); s = (nb == b); x = (nb == '0);
                     fill_st(e + 2, s, x);
                     b = nb;
                     if (s || x || g == GMAX) begin
                        e_done[e+2] = 1;
                        stop = 1;
                     end
                     t = e + 2;
                  end
                  m_board = b; m_gen = g; m_idle_at = t; m_run = 1;
               end
            end
            default: e_err[a] = 1;
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && cyc < MAXC) begin
         chk("board_load", board_load, e_load[cyc]);
         chk("board_ena",  board_ena,  e_ena[cyc]);
         chk("done",       done,       e_done[cyc]);
         chk("cmd_err",    cmd_err,    e_err[cyc]);
         chk("busy",       busy,       e_busy[cyc]);
         chk("cmd_ready",  cmd_ready,  e_ready[cyc]);
         chk("generation", generation, e_gen[cyc]);
         chk("stable",     stable,     e_stable[cyc]);
         chk("extinct",    extinct,    e_ext[cyc]);
         chk("board_seed", board_seed, e_seed[cyc]);
      end
   end

   task automatic send(input int op, input int per, input logic [N-1:0] sd, output int acc);
      bit got;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_period = per[PER_W-1:0]; seed = sd;
      got = 0; acc = 0;
      for (int i = 0; i < 64 && !got; i++) begin
         if (cmd_ready === 1'b1) begin
            acc = cyc + 1;
            m_accept(op, per, sd, acc);
            got = 1;
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL accept op=%0d got=no-ready expected=ready", op);
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      while (cyc < m_idle_at + 1) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int a, a0, c0;
      bit seen;
      m_reset(0);
      m_board = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready",   cmd_ready,  1);
      chk("rst_busy",    busy,       0);
      chk("rst_gen",     generation, 0);
      chk("rst_seed",    board_seed, 0);
      chk("rst_strobes", {board_load, board_ena, done, cmd_err, stable, extinct}, 0);
      rst = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;

      // Blinker load and two steps.
      send(OP_LOAD, 0, BLINK, a);
      wait_idle();
      chk("lit_seed", board_seed, BLINK);
      chk("lit_gen0", generation, 0);
      send(OP_STEP, 0, '0, a);
      wait_idle();
      chk("lit_step1_board", board_q, VBLINK);
      chk("lit_step1_gen", generation, 1);
      chk("lit_step1_flags", {stable, extinct}, 2'b00);
      send(OP_STEP, 0, '0, a);
      wait_idle();
      chk("lit_step2_board", board_q, BLINK);
      chk("lit_step2_gen", generation, 2);
      chk("lit_step2_stable", stable, 0);

      // Block: still life stops a run after one generation.
      send(OP_LOAD, 0, BLOCK, a);
      send(OP_RUN, 4, '0, a);
      wait_idle();
      chk("lit_block_stable", stable, 1);
      chk("lit_block_gen", generation, 1);

      // Single cell with period 0: dies in one generation.
      send(OP_LOAD, 0, SINGLE, a);
      c0 = ena_cnt;
      send(OP_RUN, 0, '0, a);
      wait_idle();
      chk("lit_single_extinct", extinct, 1);
      chk("lit_single_gen", generation, 1);
      chk("lit_single_enas", ena_cnt - c0, 1);

      // Blinker run with an ignored STEP and a HALT mid-wait.
      send(OP_LOAD, 0, BLINK, a);
      c0 = ena_cnt;
      send(OP_RUN, 10, '0, a0);
      send(OP_STEP, 0, '0, a);
      while (cyc < a0 + 13) @(negedge clk);
      send(OP_HALT, 0, '0, a);
      wait_idle();
      repeat (12) @(negedge clk);
      chk("lit_halt_gen", generation, 1);
      chk("lit_halt_enas", ena_cnt - c0, 1);
      chk("lit_halt_busy", busy, 0);

      // HALT while idle is an error.
      send(OP_HALT, 0, '0, a);
      wait_idle();

      // Saturation at generation 3.
      send(OP_LOAD, 0, BLINK, a);
      c0 = ena_cnt;
      send(OP_RUN, 2, '0, a);
      wait_idle();
      chk("lit_sat_gen", generation, 3);
      chk("lit_sat_enas", ena_cnt - c0, 3);
      c0 = ena_cnt;
      send(OP_STEP, 0, '0, a);
      send(OP_RUN, 1, '0, a);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("lit_sat_noena", ena_cnt - c0, 0);
      chk("lit_sat_gen_hold", generation, 3);

      // Asynchronous reset during RUN_ENA.
      send(OP_LOAD, 0, BLINK, a);
      send(OP_RUN, 3, '0, a);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (board_ena === 1'b1) seen = 1;
      end
      chk("rst_ena_seen", seen, 1);
      chk_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_ena",   board_ena,  0);
      chk("arst_gen",   generation, 0);
      chk("arst_busy",  busy,       0);
      chk("arst_ready", cmd_ready,  1);
      chk("arst_seed",  board_seed, 0);
      chk("arst_other", {board_load, done, cmd_err, stable, extinct}, 0);
      @(negedge clk);
      rst = 1'b0;
      m_reset(cyc);
      m_board = BLINK;
      @(posedge clk);
      chk_en = 1'b1;
      send(OP_STEP, 0, '0, a);
      wait_idle();
      chk("lit_post_rst_board", board_q, VBLINK);
      chk("lit_post_rst_gen", generation, 1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
